// File: rtl/alu_cc_sink_if.sv
// alu_cc_sink_if: ALU-result handshake between the execute-stage ALU (master)
// and the condition-code sink (slave), including the registered output side
// facing memory/writeback.
interface alu_cc_sink_if #(
  parameter int WIDTH = 64
);
  // ALU result side
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_ctrl;
  logic signed [WIDTH-1:0] in_result;
  logic                    in_ovf;
  logic                    in_set_cc;
  logic [3:0]              in_ifun;
  // Memory/writeback side
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_result;
  logic                    out_cnd;
  logic [2:0]              out_cc;
  logic                    out_err;

  modport master (
    output in_valid, in_ctrl, in_result, in_ovf, in_set_cc, in_ifun, out_ready,
    input  in_ready, out_valid, out_result, out_cnd, out_cc, out_err
  );

  modport slave (
    input  in_valid, in_ctrl, in_result, in_ovf, in_set_cc, in_ifun, out_ready,
    output in_ready, out_valid, out_result, out_cnd, out_cc, out_err
  );
endinterface

// File: rtl/alu_cc_sink.sv
// alu_cc_sink: consumer of ALU results in the Y86 execute stage. Updates the
// {ZF,SF,OF} condition-code register, evaluates the jXX/cmovXX condition
// against the post-update flags, and holds result/condition/flags in a
// one-entry output register with valid/ready flow control.
// Optional build macro CC_OVF_COUNT_EN adds a saturating 16-bit counter of
// flag-setting overflows (ovf_count) with a synchronous clear (ovf_clr).
module alu_cc_sink #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] RESET_CC = 3'b100
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cc_sink_if.slave      bus
`ifdef CC_OVF_COUNT_EN
  ,
  input  logic              ovf_clr,
  output logic [15:0]       ovf_count
`endif
);

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Arithmetic ops may overflow; logical ops never report overflow.
  function automatic logic of_mask(input logic [1:0] ctrl, input logic ovf);
    return ovf && ((ctrl == CTRL_ADD) || (ctrl == CTRL_SUB));
  endfunction

  // Only function codes 0..6 name a Y86 condition.
  function automatic logic ifun_valid(input logic [3:0] ifun);
    return ifun <= 4'd6;
  endfunction

  // Y86 condition table over {ZF,SF,OF}; undefined codes evaluate false.
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    logic r;
    zf = cc[2];
    sf = cc[1];
    of = cc[0];
    case (ifun)
      4'd0:    r = 1'b1;
      4'd1:    r = (sf ^ of) | zf;
      4'd2:    r = sf ^ of;
      4'd3:    r = zf;
      4'd4:    r = !zf;
      4'd5:    r = !(sf ^ of);
      4'd6:    r = !(sf ^ of) && !zf;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t                  state_q;
  state_t                  state_d;
  logic                    accept_p0;
  logic                    vld_p1;

  logic [2:0]              cc_q;
  logic [2:0]              cc_upd_p0;
  logic [2:0]              cc_eff_p0;
  logic                    cnd_p0;
  logic                    err_p0;

  logic signed [WIDTH-1:0] result_p1;
  logic                    cnd_p1;
  logic [2:0]              cc_p1;
  logic                    err_p1;

  // ---- Stage p0: handshake and flag/condition evaluation ----

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state: fill on accept, drain when the consumer takes the entry and nothing replaces it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept_p0) state_d = FULL;
      FULL:    if (bus.out_ready && !accept_p0) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM outputs: entry-held flag and combinational ready that allows a same-cycle reload.
  always_comb begin
    vld_p1        = (state_q == FULL);
    bus.out_valid = vld_p1;
    bus.in_ready  = !vld_p1 || bus.out_ready;
    accept_p0     = bus.in_valid && bus.in_ready;
  end

  // Candidate flags from this result, and the flags the condition sees (own update when set_cc).
  always_comb begin
    cc_upd_p0 = {(bus.in_result == '0), bus.in_result[WIDTH-1], of_mask(bus.in_ctrl, bus.in_ovf)};
    cc_eff_p0 = bus.in_set_cc ? cc_upd_p0 : cc_q;
    cnd_p0    = cond_eval(bus.in_ifun, cc_eff_p0);
    err_p0    = !ifun_valid(bus.in_ifun);
  end

  // Architectural condition-code register; only accepted flag-setting results touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cc_q <= RESET_CC;
    else if (accept_p0 && bus.in_set_cc) cc_q <= cc_upd_p0;
  end

  // ---- Stage p1: registered entry toward memory/writeback ----

  // Load a new entry on every accept; otherwise hold so a stalled consumer sees stable data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1 <= '0;
      cnd_p1    <= 1'b0;
      cc_p1     <= RESET_CC;
      err_p1    <= 1'b0;
    end else if (accept_p0) begin
      result_p1 <= bus.in_result;
      cnd_p1    <= cnd_p0;
      cc_p1     <= cc_eff_p0;
      err_p1    <= err_p0;
    end
  end

  assign bus.out_result = result_p1;
  assign bus.out_cnd    = cnd_p1;
  assign bus.out_cc     = cc_p1;
  assign bus.out_err    = err_p1;

`ifdef CC_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q;
  logic        ovf_hit_p0;

  assign ovf_hit_p0 = accept_p0 && bus.in_set_cc && cc_upd_p0[0];

  // Saturating overflow counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  ovf_cnt_q <= 16'h0000;
    else if (ovf_clr)                            ovf_cnt_q <= 16'h0000;
    else if (ovf_hit_p0 && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'h0001;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cc_sink.sv
// tb_alu_cc_sink: directed testbench for alu_cc_sink.
module tb_alu_cc_sink;
  localparam int WIDTH = 64;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_cc_sink_if #(.WIDTH(WIDTH)) bus ();

`ifdef CC_OVF_COUNT_EN
  logic        ovf_clr;
  logic [15:0] ovf_count;
`endif

  alu_cc_sink #(.WIDTH(WIDTH), .RESET_CC(3'b100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef CC_OVF_COUNT_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [1:0] ctrl, input logic [63:0] res, input logic ovf,
                       input logic sc, input logic [3:0] ifun);
    bus.in_ctrl   = ctrl;
    bus.in_result = res;
    bus.in_ovf    = ovf;
    bus.in_set_cc = sc;
    bus.in_ifun   = ifun;
  endtask

  // One accepted transfer (out_ready is high, so in_ready is high).
  task automatic send(input logic [1:0] ctrl, input logic [63:0] res, input logic ovf,
                      input logic sc, input logic [3:0] ifun);
    drive(ctrl, res, ovf, sc, ifun);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_cc !== 3'b100) begin n_err++; $display("FAIL rst_out_cc: got %b want 100", bus.out_cc); end
    @(negedge clk); rst_n = 1'b1;
    send(2'b00, 64'd1, 1'b1, 1'b1, 4'd0);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_cc !== 3'b001) begin n_err++; $display("FAIL pre_rst_entry: got valid=%b cc=%b want 1/001", bus.out_valid, bus.out_cc); end
    // Asynchronous assertion in the middle of the high phase.
    #2; rst_n = 1'b0; #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_cc !== 3'b100) begin n_err++; $display("FAIL async_rst_cc: got %b want 100", bus.out_cc); end
    n_vec++; if (bus.out_cnd !== 1'b0) begin n_err++; $display("FAIL async_rst_cnd: got %b want 0", bus.out_cnd); end
    n_vec++; if (bus.out_result !== 64'd0) begin n_err++; $display("FAIL async_rst_result: got %h want 0", bus.out_result); end
    @(negedge clk); rst_n = 1'b1;
    // Flags after reset must be RESET_CC: ifun=3 (e) with set_cc=0 sees ZF=1.
    send(2'b00, 64'd7, 1'b0, 1'b0, 4'd3);
    n_vec++; if (bus.out_cnd !== 1'b1 || bus.out_cc !== 3'b100) begin n_err++; $display("FAIL post_rst_cc: got cnd=%b cc=%b want 1/100", bus.out_cnd, bus.out_cc); end
  endtask

  task automatic test_add_ovf;
    send(2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 4'd2);
    n_vec++; if (bus.out_cc !== 3'b011) begin n_err++; $display("FAIL add_ovf_cc: got %b want 011", bus.out_cc); end
    n_vec++; if (bus.out_cnd !== 1'b0) begin n_err++; $display("FAIL add_ovf_l: got %b want 0", bus.out_cnd); end
    n_vec++; if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL add_ovf_result: got %h want fffffffffffffffe", bus.out_result); end
    send(2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 4'd5);
    n_vec++; if (bus.out_cnd !== 1'b1) begin n_err++; $display("FAIL add_ovf_ge: got %b want 1", bus.out_cnd); end
    n_vec++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL add_ovf_err: got %b want 0", bus.out_err); end
  endtask

  task automatic test_sub_zero;
    send(2'b01, 64'd0, 1'b0, 1'b1, 4'd1);
    n_vec++; if (bus.out_cc !== 3'b100) begin n_err++; $display("FAIL sub_zero_cc: got %b want 100", bus.out_cc); end
    n_vec++; if (bus.out_cnd !== 1'b1) begin n_err++; $display("FAIL sub_zero_le: got %b want 1", bus.out_cnd); end
    send(2'b00, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 4'd4);
    n_vec++; if (bus.out_cnd !== 1'b0) begin n_err++; $display("FAIL no_setcc_ne: got %b want 0", bus.out_cnd); end
    n_vec++; if (bus.out_cc !== 3'b100) begin n_err++; $display("FAIL no_setcc_cc: got %b want 100", bus.out_cc); end
  endtask

  task automatic test_logic_mask;
    send(2'b11, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 4'd6);
    n_vec++; if (bus.out_cc !== 3'b010) begin n_err++; $display("FAIL xor_mask_cc: got %b want 010", bus.out_cc); end
    n_vec++; if (bus.out_cnd !== 1'b0) begin n_err++; $display("FAIL xor_mask_g: got %b want 0", bus.out_cnd); end
    send(2'b10, 64'd0, 1'b1, 1'b1, 4'd3);
    n_vec++; if (bus.out_cc !== 3'b100 || bus.out_cnd !== 1'b1) begin n_err++; $display("FAIL and_mask: got cc=%b cnd=%b want 100/1", bus.out_cc, bus.out_cnd); end
  endtask

  task automatic test_invalid;
    send(2'b00, 64'd5, 1'b0, 1'b1, 4'd9);
    n_vec++; if (bus.out_err !== 1'b1) begin n_err++; $display("FAIL inv_err: got %b want 1", bus.out_err); end
    n_vec++; if (bus.out_cnd !== 1'b0) begin n_err++; $display("FAIL inv_cnd: got %b want 0", bus.out_cnd); end
    n_vec++; if (bus.out_cc !== 3'b000) begin n_err++; $display("FAIL inv_cc: got %b want 000", bus.out_cc); end
    send(2'b00, 64'd5, 1'b0, 1'b0, 4'd0);
    n_vec++; if (bus.out_err !== 1'b0 || bus.out_cnd !== 1'b1) begin n_err++; $display("FAIL inv_clear: got err=%b cnd=%b want 0/1", bus.out_err, bus.out_cnd); end
  endtask

  task automatic test_backpressure;
    // A: holds in the output register while the consumer stalls.
    send(2'b00, 64'd0, 1'b0, 1'b1, 4'd3);
    n_vec++; if (bus.out_cc !== 3'b100 || bus.out_cnd !== 1'b1) begin n_err++; $display("FAIL bp_a: got cc=%b cnd=%b want 100/1", bus.out_cc, bus.out_cnd); end
    bus.out_ready = 1'b0;
    // B presented while stalled.
    drive(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'd2);
    bus.in_valid = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_result !== 64'd0 || bus.out_cc !== 3'b100 || bus.out_cnd !== 1'b1 || bus.in_ready !== 1'b0)
        begin n_err++; $display("FAIL bp_frozen%0d: got v=%b r=%h cc=%b cnd=%b rdy=%b want 1/0/100/1/0", i, bus.out_valid, bus.out_result, bus.out_cc, bus.out_cnd, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    n_vec++; if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.out_cc !== 3'b010 || bus.out_cnd !== 1'b1)
      begin n_err++; $display("FAIL bp_b: got r=%h cc=%b cnd=%b want ffffffffffffffff/010/1", bus.out_result, bus.out_cc, bus.out_cnd); end
    drive(2'b01, 64'd3, 1'b0, 1'b1, 4'd6);
    @(posedge clk); #1;
    n_vec++; if (bus.out_result !== 64'd3 || bus.out_cc !== 3'b000 || bus.out_cnd !== 1'b1)
      begin n_err++; $display("FAIL bp_c: got r=%h cc=%b cnd=%b want 3/000/1", bus.out_result, bus.out_cc, bus.out_cnd); end
    drive(2'b10, 64'd9, 1'b1, 1'b0, 4'd3);
    @(posedge clk); #1;
    n_vec++; if (bus.out_result !== 64'd9 || bus.out_cc !== 3'b000 || bus.out_cnd !== 1'b0)
      begin n_err++; $display("FAIL bp_d: got r=%h cc=%b cnd=%b want 9/000/0", bus.out_result, bus.out_cc, bus.out_cnd); end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got valid=%b want 0", bus.out_valid); end
  endtask

`ifdef CC_OVF_COUNT_EN
  task automatic test_ovf_count;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    n_vec++; if (ovf_count !== 16'd0) begin n_err++; $display("FAIL ovf_clr_idle: got %0d want 0", ovf_count); end
    for (int i = 0; i < 3; i++) send(2'b00, 64'h7, 1'b1, 1'b1, 4'd0);
    send(2'b11, 64'h7, 1'b1, 1'b1, 4'd0);
    send(2'b00, 64'h7, 1'b1, 1'b0, 4'd0);
    n_vec++; if (ovf_count !== 16'd3) begin n_err++; $display("FAIL ovf_count3: got %0d want 3", ovf_count); end
    ovf_clr = 1'b1;
    send(2'b01, 64'h7, 1'b1, 1'b1, 4'd0);
    ovf_clr = 1'b0;
    n_vec++; if (ovf_count !== 16'd0) begin n_err++; $display("FAIL ovf_clr_prio: got %0d want 0", ovf_count); end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(2'b00, 64'd0, 1'b0, 1'b0, 4'd0);
`ifdef CC_OVF_COUNT_EN
    ovf_clr = 1'b0;
`endif
    test_reset();
    test_add_ovf();
    test_sub_zero();
    test_logic_mask();
    test_invalid();
    test_backpressure();
`ifdef CC_OVF_COUNT_EN
    test_ovf_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_cc_sink.md
Name: alu_cc_sink

Overview:
- Consumer end of the ALU result interface in the Y86 execute stage.
- Accepts ALU results (out, overflow, control) through a valid/ready handshake.
- Updates the condition-code register (ZF, SF, OF) and evaluates the Y86 jXX/cmovXX condition for the instruction.
- Presents result, condition and flags through a one-entry registered output stage toward memory/writeback.

Parameters:
- WIDTH, 64, datapath width of the ALU result.
- RESET_CC, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result presented.
- in_ready  output  1  block can accept this cycle.
- in_ctrl  input  2  ALU control: 00 add, 01 sub, 10 and, 11 xor.
- in_result  input  WIDTH  signed ALU output.
- in_ovf  input  1  ALU overflow flag.
- in_set_cc  input  1  update CC with this result (OPq only).
- in_ifun  input  4  condition function code.
- out_valid  output  1  output register holds an entry.
- out_ready  input  1  downstream accepts the entry.
- out_result  output  WIDTH  registered ALU result.
- out_cnd  output  1  evaluated condition.
- out_cc  output  3  {ZF,SF,OF} after this entry.
- out_err  output  1  in_ifun was an invalid code.

Behaviour:
- Reset (async, rst_n=0):
  - CC = RESET_CC; out_valid = 0; out_result = 0; out_cnd = 0; out_cc = RESET_CC; out_err = 0.
  - Reset mid-transfer discards the held entry; no partial update survives.
- Output stage FSM, two states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - in_ready = !out_valid || out_ready, combinational.
  - accept = in_valid && in_ready.
  - EMPTY: accept -> FULL.
  - FULL: out_ready && !accept -> EMPTY; accept (with out_ready) -> FULL, reloaded with the new entry.
  - FULL with !out_ready: in_ready=0; output fields and CC are held stable.
- Latency: accepted input appears on out_* the next cycle. Throughput is 1 per cycle while out_ready=1.
- CC update, on accept with in_set_cc=1:
  - ZF = (in_result == 0).
  - SF = in_result[WIDTH-1].
  - OF = in_ovf && (in_ctrl == 00 or 01). Logical ops (and, xor) force OF=0 regardless of in_ovf.
  - With in_set_cc=0, CC is unchanged.
- Condition evaluation uses the CC value after this entry's update, so an OPq result's own flags are visible to its own in_ifun.
  - 0 always: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF) && !ZF
  - 7–15: cnd=0, out_err=1; CC is still updated if in_set_cc=1.
- out_cc carries the post-update CC registered with the entry. out_err clears on the next accepted valid code.
- in_valid=1 with in_ready=0: input is not consumed. The source must hold its values; the block does not check this.
- No wrap-around or saturation of the result; in_result is passed through unmodified.

Optional Feature:
- Macro CC_OVF_COUNT_EN.
- When defined:
  - Adds output ovf_count (16 bits) and input ovf_clr (1 bit).
  - ovf_count increments on each accept with in_set_cc=1 and computed OF=1.
  - Saturates at 16'hFFFF.
  - ovf_clr=1 zeroes it next cycle and takes priority over a simultaneous increment.
  - Reset value is 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle -> immediately out_valid=0, out_cc=3'b100, out_cnd=0, out_result=0.
- Add overflow: ctrl=00, result=64'hFFFF_FFFF_FFFF_FFFE, ovf=1, set_cc=1, ifun=2 (l) -> next cycle out_cc=3'b011, out_cnd=0. Same stimulus with ifun=5 (ge) -> out_cnd=1.
- Sub to zero: ctrl=01, result=0, ovf=0, set_cc=1, ifun=1 (le) -> out_cc=3'b100, out_cnd=1. Follow with set_cc=0, ifun=4 (ne) -> out_cnd=0, CC unchanged.
- Logical OF masking: ctrl=11, result=64'h8000_0000_0000_0000, ovf=1, set_cc=1, ifun=6 (g) -> out_cc=3'b010, out_cnd=0.
- Backpressure:
  - Stream 3 entries with out_ready=0 after the first -> in_ready=0, out_* frozen, CC not updated by the stalled inputs.
  - Raise out_ready -> entries drain in order, one per cycle.
- Invalid ifun=9 with set_cc=1, result=5 -> out_err=1, out_cnd=0, out_cc=3'b000. With CC_OVF_COUNT_EN, 3 overflowing adds -> ovf_count=3; ovf_clr together with a 4th overflowing add -> ovf_count=0.
